alu_cmd_ctrl: RTL and testbench
===============================

Name: alu_cmd_ctrl

Overview:
- Initiator side of the combinational ALU interface (operands a, b, 3-bit op -> result).
- Accepts tagged ALU commands over a valid/ready stream and buffers them in a small FIFO.
- Drives registered operands and opcode to an external ALU instance, captures its result, and returns a tagged response with zero/error flags over a second valid/ready stream.
- Sits between a command source (sequencer or bus adapter) and the ALU datapath.

Parameters:
- WIDTH, 8: operand/result width; must match the attached ALU.
- DEPTH, 4: command FIFO entries; power of two, >= 2.
- TAGW, 4: command/response tag width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- cmd_valid  input  1  command present
- cmd_ready  output  1  command accepted when high with cmd_valid
- cmd_op  input  3  ALU opcode
- cmd_a  input  WIDTH  operand a
- cmd_b  input  WIDTH  operand b
- cmd_tag  input  TAGW  command tag, returned unchanged
- alu_a  output  WIDTH  operand a to ALU
- alu_b  output  WIDTH  operand b to ALU
- alu_op  output  3  opcode to ALU
- alu_result  input  WIDTH  combinational result from ALU
- rsp_valid  output  1  response present
- rsp_ready  input  1  response consumed when high with rsp_valid
- rsp_result  output  WIDTH  captured ALU result
- rsp_tag  output  TAGW  tag of the originating command
- rsp_zero  output  1  rsp_result == 0
- rsp_err  output  1  opcode was illegal (3'b101..3'b111)

Behaviour:
- Clock and reset: single clock domain; rst is synchronous and active-high.
- Reset clears: FIFO (empty), state=IDLE, alu_a/alu_b=0, alu_op=3'b000, rsp_valid=0, rsp_result=0, rsp_tag=0, rsp_zero=0, rsp_err=0.
- Reset asserted mid-operation discards all buffered commands and any pending response. No response is emitted for them.
- cmd_ready = !fifo_full. The value is registered-state-derived only and does not depend on cmd_valid or rsp_ready.
- A push occurs on cmd_valid && cmd_ready. When the FIFO is full, no push is accepted even if a pop happens in the same cycle.
- FIFO order is strict first-in, first-out. Pointers wrap modulo DEPTH and are tracked with an extra wrap bit to separate full from empty.
- FSM states: IDLE, DRIVE, RESP.
  - IDLE: if !empty, load alu_a/alu_b/alu_op and the tag register from the FIFO head, pop, and go to DRIVE. Otherwise stay.
  - DRIVE: alu_* are stable for the whole cycle. At the clock edge, capture rsp_result=alu_result, rsp_tag, rsp_zero=(alu_result==0), rsp_err=(alu_op>3'b100), set rsp_valid=1, and go to RESP.
  - RESP: hold all rsp_* stable while rsp_valid && !rsp_ready.
    - On handshake with FIFO !empty: load the next head into alu_*, pop, clear rsp_valid, go to DRIVE.
    - On handshake with FIFO empty: clear rsp_valid, go to IDLE.
- alu_* hold their last value outside DRIVE; they are never cleared except by reset.
- Latency: command accepted at edge k -> rsp_valid high in cycle k+3 (FIFO empty, FSM IDLE, rsp_ready=1).
- Throughput: one response per 2 cycles sustained.
- Illegal opcode: still issued to the ALU. rsp_result takes whatever the ALU returns (0 by ALU definition), rsp_err=1, and rsp_zero is computed normally.
- Arithmetic is performed entirely by the ALU. This block never modifies the result. Widths pass through unchanged, and WIDTH-bit wrap-around is the ALU's.
- Back-pressure: with rsp_ready held low, exactly 1+DEPTH commands are accepted (one held in RESP, DEPTH in the FIFO), then cmd_ready=0.

Decomposition:
- Package alu_pkg:
  - opcode localparams OP_ADD=3'b000, OP_SUB=3'b001, OP_AND=3'b010, OP_OR=3'b011, OP_XOR=3'b100, OP_LAST_LEGAL=3'b100
  - typedef enum for FSM states {IDLE, DRIVE, RESP}
  - packed cmd struct {op, tag} (operand widths remain parameterised in the module)
- Sub-module: alu_cmd_fifo, a parameterised synchronous FIFO (WIDTH, DEPTH) with push/pop/full/empty, instantiated once holding {op, a, b, tag}.

Test Plan:
- Reset then single ADD: a=0xF0, b=0x20, tag=3, rsp_ready=1 -> rsp_valid in cycle k+3 with rsp_result=0x10, rsp_tag=3, rsp_zero=0, rsp_err=0.
- SUB: a=0x05, b=0x07 -> rsp_result=0xFE. XOR: a=0x5A, b=0x5A -> rsp_result=0x00, rsp_zero=1.
- Illegal op 3'b110: a=0x12, b=0x34 -> rsp_result=0x00, rsp_err=1, rsp_zero=1, tag preserved.
- Back-pressure: rsp_ready=0, stream 8 commands with tags 0..7 -> cmd_ready drops after 5 accepted. Responses stay stable while stalled. Releasing rsp_ready yields tags 0,1,2,3,4 in order, then tags 5..7 are accepted and returned.
- Reset mid-stream: 3 commands queued, rst high for 1 cycle while in RESP -> rsp_valid=0 the next cycle, FIFO empty, no stale responses. A new command after reset returns normally.
- Full-FIFO boundary: FIFO full with cmd_valid=1, and a pop occurs in the same cycle -> that cycle's command is not accepted (cmd_ready=0). It is accepted on the following cycle.

Source files
------------

// File: rtl/alu_pkg.sv
// rtl/alu_pkg.sv - shared opcodes, FSM states and command header type
// Purpose: common definitions for the ALU command controller and its bench.
// Ports: none (package).
package alu_pkg;

  localparam logic [2:0] OP_ADD        = 3'b000;
  localparam logic [2:0] OP_SUB        = 3'b001;
  localparam logic [2:0] OP_AND        = 3'b010;
  localparam logic [2:0] OP_OR         = 3'b011;
  localparam logic [2:0] OP_XOR        = 3'b100;
  localparam logic [2:0] OP_LAST_LEGAL = 3'b100;

  // Tag width carried by cmd_t; the controller's TAGW defaults to this.
  localparam int TAG_BITS = 4;

  typedef enum logic [1:0] {
    IDLE,
    DRIVE,
    RESP
  } state_t;

  // Header of the command currently issued to the ALU.
  typedef struct packed {
    logic [2:0]          op;
    logic [TAG_BITS-1:0] tag;
  } cmd_t;

endpackage

// File: rtl/alu_cmd_fifo.sv
// rtl/alu_cmd_fifo.sv - synchronous first-in first-out command buffer
// Purpose: DEPTH-entry FIFO with extra pointer wrap bit for full/empty.
// Ports: clk, rst (sync, active-high); push/push_data write when not full;
//        pop advances head when not empty; pop_data is the current head;
//        full/empty status flags.
module alu_cmd_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;

  // Same index with differing wrap bits means the writer has lapped the reader.
  assign full     = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign empty    = (wr_ptr == rd_ptr);
  assign pop_data = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_ptr[AW-1:0]] <= push_data;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop && !empty) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/alu_cmd_ctrl.sv
// rtl/alu_cmd_ctrl.sv - tagged command front end for a combinational ALU
// Purpose: buffers tagged ALU commands, drives registered operands to an
//          external ALU, captures its result and returns a tagged response.
// Ports: clk, rst (sync, active-high);
//        cmd_valid/cmd_ready/cmd_op/cmd_a/cmd_b/cmd_tag  command stream in;
//        alu_a/alu_b/alu_op out, alu_result in        external ALU;
//        rsp_valid/rsp_ready/rsp_result/rsp_tag/rsp_zero/rsp_err  response out.
module alu_cmd_ctrl
  import alu_pkg::*;
#(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4,
  parameter int TAGW  = TAG_BITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_a,
  input  logic [WIDTH-1:0] cmd_b,
  input  logic [TAGW-1:0]  cmd_tag,
  output logic [WIDTH-1:0] alu_a,
  output logic [WIDTH-1:0] alu_b,
  output logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] alu_result,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [WIDTH-1:0] rsp_result,
  output logic [TAGW-1:0]  rsp_tag,
  output logic             rsp_zero,
  output logic             rsp_err
);

  localparam int EW = 3 + TAGW + 2 * WIDTH;

  logic [EW-1:0]    fifo_in;
  logic [EW-1:0]    fifo_head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;

  state_t           state;
  state_t           state_next;
  logic             load;
  logic             capture;
  logic             rsp_done;

  cmd_t             iss_q;
  logic [WIDTH-1:0] a_q;
  logic [WIDTH-1:0] b_q;

  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && !fifo_full;
  assign fifo_in   = {cmd_op, cmd_tag, cmd_a, cmd_b};

  alu_cmd_fifo #(
    .WIDTH (EW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (fifo_push),
    .push_data (fifo_in),
    .pop       (load),
    .pop_data  (fifo_head),
    .full      (fifo_full),
    .empty     (fifo_empty)
  );

  assign alu_a  = a_q;
  assign alu_b  = b_q;
  assign alu_op = iss_q.op;

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // load: pop the FIFO head into the ALU operand registers.
  // capture: latch the ALU result into the response registers.
  // rsp_done: the held response was consumed this cycle.
  always_comb begin
    state_next = state;
    load       = 1'b0;
    capture    = 1'b0;
    rsp_done   = 1'b0;
    case (state)
      IDLE: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = DRIVE;
        end
      end
      DRIVE: begin
        capture    = 1'b1;
        state_next = RESP;
      end
      RESP: begin
        if (rsp_ready) begin
          rsp_done = 1'b1;
          if (!fifo_empty) begin
            load       = 1'b1;
            state_next = DRIVE;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      a_q        <= '0;
      b_q        <= '0;
      iss_q      <= '0;
      rsp_valid  <= 1'b0;
      rsp_result <= '0;
      rsp_tag    <= '0;
      rsp_zero   <= 1'b0;
      rsp_err    <= 1'b0;
    end else begin
      if (load) begin
        iss_q <= '{op:  fifo_head[EW-1 -: 3],
                   tag: TAG_BITS'(fifo_head[2*WIDTH +: TAGW])};
        a_q   <= fifo_head[WIDTH +: WIDTH];
        b_q   <= fifo_head[0 +: WIDTH];
      end
      if (capture) begin
        rsp_valid  <= 1'b1;
        rsp_result <= alu_result;
        rsp_tag    <= TAGW'(iss_q.tag);
        rsp_zero   <= (alu_result == '0);
        rsp_err    <= (iss_q.op > OP_LAST_LEGAL);
      end else if (rsp_done) begin
        rsp_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_alu_cmd_ctrl.sv
// tb/tb_alu_cmd_ctrl.sv - self-checking bench for alu_cmd_ctrl
module tb_alu_cmd_ctrl;
  import alu_pkg::*;

  localparam int W = 8;
  localparam int D = 4;
  localparam int T = 4;

  logic         clk = 1'b0;
  logic         rst;
  logic         cmd_valid;
  logic         cmd_ready;
  logic [2:0]   cmd_op;
  logic [W-1:0] cmd_a;
  logic [W-1:0] cmd_b;
  logic [T-1:0] cmd_tag;
  logic [W-1:0] alu_a;
  logic [W-1:0] alu_b;
  logic [2:0]   alu_op;
  logic [W-1:0] alu_result;
  logic         rsp_valid;
  logic         rsp_ready;
  logic [W-1:0] rsp_result;
  logic [T-1:0] rsp_tag;
  logic         rsp_zero;
  logic         rsp_err;

  always #5 clk = ~clk;

  alu_cmd_ctrl #(.WIDTH(W), .DEPTH(D), .TAGW(T)) dut (
    .clk        (clk),
    .rst        (rst),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_op     (cmd_op),
    .cmd_a      (cmd_a),
    .cmd_b      (cmd_b),
    .cmd_tag    (cmd_tag),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_op     (alu_op),
    .alu_result (alu_result),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_tag    (rsp_tag),
    .rsp_zero   (rsp_zero),
    .rsp_err    (rsp_err)
  );

  // Stand-in for the attached combinational ALU.
  function automatic logic [W-1:0] alu_fn(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
    case (op)
      OP_ADD:  return a + b;
      OP_SUB:  return a - b;
      OP_AND:  return a & b;
      OP_OR:   return a | b;
      OP_XOR:  return a ^ b;
      default: return '0;
    endcase
  endfunction

  always_comb alu_result = alu_fn(alu_op, alu_a, alu_b);

  typedef struct packed {
    logic [W-1:0] res;
    logic [T-1:0] tag;
    logic         zero;
    logic         err;
  } exp_t;

  exp_t         exp_q[$];
  logic [T-1:0] seen_tags[$];
  logic [W-1:0] exp_r;
  int           n_checks = 0;
  int           n_pass   = 0;
  bit           prev_stall = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act === req) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
  endtask

  // Reference: every accepted command yields exactly one response, in order.
  always @(posedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (rsp_valid && rsp_ready && exp_q.size() > 0) begin
        seen_tags.push_back(rsp_tag);
        void'(exp_q.pop_front());
      end
      if (cmd_valid && cmd_ready) begin
        exp_r = alu_fn(cmd_op, cmd_a, cmd_b);
        exp_q.push_back('{res: exp_r, tag: cmd_tag, zero: (exp_r == '0), err: (cmd_op > OP_LAST_LEGAL)});
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall) check("rsp_held_valid", rsp_valid, 1);
      if (exp_q.size() == 0) begin
        check("no_stale_rsp", rsp_valid, 0);
      end else if (rsp_valid) begin
        check("rsp_result", rsp_result, exp_q[0].res);
        check("rsp_tag", rsp_tag, exp_q[0].tag);
        check("rsp_zero", rsp_zero, exp_q[0].zero);
        check("rsp_err", rsp_err, exp_q[0].err);
      end
      // Occupancy bound: ready implies room, not-ready implies a full FIFO.
      check("cmd_ready_occupancy",
            cmd_ready ? (exp_q.size() <= D) : (exp_q.size() >= D), 1);
      prev_stall = rsp_valid && !rsp_ready;
    end
  end

  task automatic send(input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b, input logic [T-1:0] tag);
    int n = 0;
    @(negedge clk);
    cmd_valid = 1'b1; cmd_op = op; cmd_a = a; cmd_b = b; cmd_tag = tag;
    while (!cmd_ready && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) check("send_timeout", cmd_ready, 1);
    @(posedge clk);
    #1 cmd_valid = 1'b0;
  endtask

  task automatic wait_rsp(output int lat);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
    end while (!rsp_valid && lat < 50);
    if (!rsp_valid) check("rsp_timeout", rsp_valid, 1);
  endtask

  task automatic one(input string nm, input logic [2:0] op, input logic [W-1:0] a, input logic [W-1:0] b,
                     input logic [T-1:0] tag, input logic [W-1:0] eres, input logic ezero, input logic eerr);
    int lat;
    send(op, a, b, tag);
    wait_rsp(lat);
    check({nm, "_latency"}, lat, 3);
    check({nm, "_result"}, rsp_result, eres);
    check({nm, "_tag"}, rsp_tag, tag);
    check({nm, "_zero"}, rsp_zero, ezero);
    check({nm, "_err"}, rsp_err, eerr);
  endtask

  task automatic drive_cmd(input int idx);
    cmd_valid = (idx < 8);
    cmd_op    = 3'($urandom_range(0, 7));
    cmd_a     = W'($urandom);
    cmd_b     = W'($urandom);
    cmd_tag   = T'(idx);
  endtask

  initial begin
    int idx;
    bit acc;
    int cnt;
    int lat;

    rst = 1'b1; cmd_valid = 1'b0; cmd_op = '0; cmd_a = '0; cmd_b = '0; cmd_tag = '0; rsp_ready = 1'b1;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check("reset_rsp_valid", rsp_valid, 0);
    check("reset_rsp_result", rsp_result, 0);
    check("reset_rsp_tag", rsp_tag, 0);
    check("reset_rsp_zero", rsp_zero, 0);
    check("reset_rsp_err", rsp_err, 0);
    check("reset_alu_a", alu_a, 0);
    check("reset_alu_b", alu_b, 0);
    check("reset_alu_op", alu_op, 0);
    check("reset_cmd_ready", cmd_ready, 1);

    one("add", OP_ADD, 8'hF0, 8'h20, 4'd3, 8'h10, 1'b0, 1'b0);
    one("sub", OP_SUB, 8'h05, 8'h07, 4'd5, 8'hFE, 1'b0, 1'b0);
    one("xor", OP_XOR, 8'h5A, 8'h5A, 4'd7, 8'h00, 1'b1, 1'b0);
    one("illegal", 3'b110, 8'h12, 8'h34, 4'd9, 8'h00, 1'b1, 1'b1);
    check("alu_op_held", alu_op, 3'b110);

    // Back-pressure: five accepted, then the full-FIFO/pop boundary.
    @(negedge clk);
    rsp_ready = 1'b0;
    seen_tags.delete();
    idx = 0;
    for (int c = 0; c < 14; c++) begin
      if (c > 0) @(negedge clk);
      drive_cmd(idx);
      acc = cmd_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    check("bp_accepted", idx, 1 + D);
    check("bp_cmd_ready_low", cmd_ready, 0);
    check("bp_rsp_valid", rsp_valid, 1);
    check("bp_rsp_tag_head", rsp_tag, 0);
    rsp_ready = 1'b1;
    drive_cmd(idx);
    check("full_pop_blocks_push", cmd_ready, 0);
    acc = cmd_ready;
    @(posedge clk);
    if (acc) idx++;
    @(negedge clk);
    check("accept_after_pop", cmd_ready, 1);
    for (int c = 0; c < 40 && idx < 8; c++) begin
      if (c > 0) @(negedge clk);
      drive_cmd(idx);
      acc = cmd_ready;
      @(posedge clk);
      if (acc) idx++;
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    cnt = 0;
    while (seen_tags.size() < 8 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("bp_all_accepted", idx, 8);
    check("bp_rsp_count", seen_tags.size(), 8);
    for (int k = 0; k < 8 && k < seen_tags.size(); k++) begin
      check($sformatf("bp_order_%0d", k), seen_tags[k], k);
    end

    // Reset while a response is stalled with commands queued.
    @(negedge clk);
    rsp_ready = 1'b0;
    send(OP_ADD, 8'h01, 8'h02, 4'd1);
    send(OP_AND, 8'hF3, 8'h3C, 4'd2);
    send(OP_OR,  8'h10, 8'h01, 4'd3);
    wait_rsp(lat);
    check("mid_in_resp", rsp_valid, 1);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_rsp_valid", rsp_valid, 0);
    check("mid_rst_cmd_ready", cmd_ready, 1);
    rsp_ready = 1'b1;
    cnt = 0;
    for (int c = 0; c < 8; c++) begin
      @(negedge clk);
      if (rsp_valid) cnt++;
    end
    check("mid_rst_no_stale", cnt, 0);
    one("post_rst_or", OP_OR, 8'h0F, 8'hF0, 4'hA, 8'hFF, 1'b0, 1'b0);

    // Randomized traffic against the reference queue.
    for (int i = 0; i < 800; i++) begin
      @(negedge clk);
      cmd_valid = ($urandom_range(0, 3) != 0);
      cmd_op    = 3'($urandom_range(0, 7));
      cmd_a     = W'($urandom);
      cmd_b     = W'($urandom);
      cmd_tag   = T'($urandom);
      rsp_ready = ($urandom_range(0, 2) != 0);
    end
    @(negedge clk);
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    cnt = 0;
    while (exp_q.size() > 0 && cnt < 60) begin
      @(negedge clk);
      cnt++;
    end
    check("drain_empty", exp_q.size(), 0);

    repeat (2) @(negedge clk);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, checks %0d/%0d", n_pass, n_checks);
    $fatal(1);
  end

endmodule
